// File: rtl/brk_game_fsm.sv
// Breakout game-flow controller: serve/play/lost/win sequencing, score
// accumulation with saturation, life counting and ball/brick reset pulses.
module brk_game_fsm #(
  parameter int SERVE_FRAMES = 60,
  parameter int PTS_PER_BRK  = 1,
  parameter int START_LIVES  = 3,
  parameter int MAX_PTS      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       score,
  input  logic       no_brks,
  input  logic       ball_lost,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       brk_rst,
  output logic [9:0] points,
  output logic [1:0] lives
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_WIN   = 3'd4
  } state_t;

  localparam int            CW       = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  // Add one brick's worth of points, clamping at the ceiling instead of wrapping.
  function automatic logic [9:0] sat_add(input logic [9:0] a);
    logic [15:0] sum;
    sum = {6'd0, a} + 16'(PTS_PER_BRK);
    if (sum > 16'(MAX_PTS)) begin
      sat_add = 10'(MAX_PTS);
    end else begin
      sat_add = sum[9:0];
    end
  endfunction

  state_t        r_state, w_state_nx;
  logic [9:0]    r_points, w_points_nx;
  logic [1:0]    r_lives, w_lives_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_ball_reset, w_ball_reset_nx;
  logic          r_brk_rst, w_brk_rst_nx;
  logic          r_start_q;
  logic          w_start_re;

  assign w_start_re = start & ~r_start_q;

  // State, counters and pulse outputs; reset also primes the start history high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_points     <= 10'd0;
      r_lives      <= 2'd0;
      r_cnt        <= '0;
      r_ball_reset <= 1'b0;
      r_brk_rst    <= 1'b0;
      r_start_q    <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_points     <= w_points_nx;
      r_lives      <= w_lives_nx;
      r_cnt        <= w_cnt_nx;
      r_ball_reset <= w_ball_reset_nx;
      r_brk_rst    <= w_brk_rst_nx;
      r_start_q    <= start;
    end
  end

  // Next-state and datapath decisions; everything holds unless an event applies.
  always_comb begin
    w_state_nx      = r_state;
    w_points_nx     = r_points;
    w_lives_nx      = r_lives;
    w_cnt_nx        = r_cnt;
    w_ball_reset_nx = 1'b0;
    w_brk_rst_nx    = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOST, ST_WIN: begin
        if (w_start_re) begin
          w_state_nx      = ST_SERVE;
          w_points_nx     = 10'd0;
          w_lives_nx      = 2'(START_LIVES);
          w_cnt_nx        = '0;
          w_ball_reset_nx = 1'b1;
          w_brk_rst_nx    = 1'b1;
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (r_cnt >= CNT_LAST) begin
            w_state_nx = ST_PLAY;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      ST_PLAY: begin
        // A brick destroyed in the same cycle as any other event still counts.
        if (score) begin
          w_points_nx = sat_add(r_points);
        end else begin
          w_points_nx = r_points;
        end
        // An empty wall wins even if the ball is lost in the same cycle.
        if (no_brks) begin
          w_state_nx = ST_WIN;
        end else if (ball_lost) begin
          if (r_lives > 2'd1) begin
            w_lives_nx      = r_lives - 2'd1;
            w_state_nx      = ST_SERVE;
            w_cnt_nx        = '0;
            w_ball_reset_nx = 1'b1;
          end else begin
            w_lives_nx = 2'd0;
            w_state_nx = ST_LOST;
          end
        end else begin
          w_state_nx = ST_PLAY;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign state      = r_state;
  assign ball_run   = (r_state == ST_PLAY);
  assign ball_reset = r_ball_reset;
  assign brk_rst    = r_brk_rst;
  assign points     = r_points;
  assign lives      = r_lives;

endmodule

// File: tb/tb_brk_game_fsm.sv
// Scoreboard bench for brk_game_fsm: a game-level reference model predicts
// each cycle's outputs, a monitor compares them against the DUT.
module tb_brk_game_fsm;

  localparam int SF  = 60;
  localparam int PPB = 1;
  localparam int SL  = 3;
  localparam int MP  = 999;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b1, frame_tick = 1'b0;
  logic       score = 1'b0, no_brks = 1'b0, ball_lost = 1'b0;
  logic [2:0] state;
  logic       ball_run, ball_reset, brk_rst;
  logic [9:0] points;
  logic [1:0] lives;

  always #5 clk = ~clk;

  brk_game_fsm #(.SERVE_FRAMES(SF), .PTS_PER_BRK(PPB), .START_LIVES(SL), .MAX_PTS(MP)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .score(score),
    .no_brks(no_brks), .ball_lost(ball_lost), .state(state), .ball_run(ball_run),
    .ball_reset(ball_reset), .brk_rst(brk_rst), .points(points), .lives(lives)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       brs;
    logic       bkr;
    logic [9:0] pts;
    logic [1:0] lv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  // Reference model: game mode uses the published output codes
  // (0 idle, 1 serve, 2 play, 3 lost, 4 win).
  int m_mode = 0, m_pts = 0, m_lives = 0, m_frames = 0;
  bit m_prev = 1'b1, m_br = 1'b0, m_bk = 1'b0;
  bit cur_start = 1'b1;

  task automatic model_step(input bit r, s, ft, sc, nb, bl);
    bit press;
    if (r) begin
      m_mode = 0; m_pts = 0; m_lives = 0; m_frames = 0;
      m_prev = 1'b1; m_br = 1'b0; m_bk = 1'b0;
    end else begin
      press  = s && !m_prev;
      m_prev = s;
      m_br   = 1'b0;
      m_bk   = 1'b0;
      if ((m_mode == 0 || m_mode == 3 || m_mode == 4) && press) begin
        m_mode = 1; m_pts = 0; m_lives = SL; m_frames = 0;
        m_br = 1'b1; m_bk = 1'b1;
      end else if (m_mode == 1 && ft) begin
        m_frames++;
        if (m_frames == SF) begin
          m_mode = 2;
          m_frames = 0;
        end
      end else if (m_mode == 2) begin
        if (sc) m_pts = (m_pts + PPB > MP) ? MP : m_pts + PPB;
        if (nb) m_mode = 4;
        else if (bl) begin
          if (m_lives > 1) begin
            m_lives--; m_mode = 1; m_frames = 0; m_br = 1'b1;
          end else begin
            m_lives = 0; m_mode = 3;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the predicted result.
  task automatic cyc(input bit r, s, ft, sc, nb, bl);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; frame_tick = ft; score = sc; no_brks = nb; ball_lost = bl;
    model_step(r, s, ft, sc, nb, bl);
    e.st  = 3'(m_mode);
    e.run = (m_mode == 2);
    e.brs = m_br;
    e.bkr = m_bk;
    e.pts = 10'(m_pts);
    e.lv  = 2'(m_lives);
    q.push_back(e);
  endtask

  task automatic serve_out();
    for (int i = 0; i < 300 && m_mode == 1; i++)
      cyc(1'b0, cur_start, i[0], $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1);
  endtask

  task automatic press_start();
    cur_start = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_start = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: just after each rising edge, compare DUT outputs with the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cyc++;
      n_tests++;
      if ({state, ball_run, ball_reset, brk_rst, points, lives} !== e) begin
        n_fail++;
        $display("FAIL cyc%0d: got st=%0d run=%0b brs=%0b bkr=%0b pts=%0d lv=%0d, want st=%0d run=%0b brs=%0b bkr=%0b pts=%0d lv=%0d",
                 n_cyc, state, ball_run, ball_reset, brk_rst, points, lives,
                 e.st, e.run, e.brs, e.bkr, e.pts, e.lv);
      end
    end
  end

  initial begin
    // Reset, then a clean press starts a game.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_start = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_start = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // 59 ticks with event noise (must stay in SERVE), then the 60th.
    for (int i = 0; i < 59; i++)
      cyc(1'b0, 1'b1, 1'b1, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Score up to the ceiling and beyond.
    for (int i = 0; i < 1000; i++)
      cyc(1'b0, 1'b1, $urandom_range(1) == 1, 1'b1, 1'b0, 1'b0);
    // Lose all three lives, serving between losses.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      serve_out();
    end
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, $urandom_range(1) == 1, 1'b1);
    press_start();
    serve_out();
    // Win with every play event in the same cycle.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Start held through reset must not start; release and press does.
    press_start();
    serve_out();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    press_start();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomised play.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) cur_start = ~cur_start;
      cyc($urandom_range(399) == 0, cur_start, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(59) == 0, $urandom_range(39) == 0);
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
